// File: rtl/conv_layer_engine_pkg.sv
// Shared constants and width helpers for the streaming box-sum convolution engine.
package conv_layer_engine_pkg;

    localparam int unsigned DEF_D_WIDTH     = 8;
    localparam int unsigned DEF_Q_WIDTH     = 16;
    localparam int unsigned DEF_D_CHANNELS  = 3;
    localparam int unsigned DEF_Q_CHANNELS  = 5;
    localparam int unsigned DEF_FILTER_SIZE = 5;
    localparam int unsigned DEF_IMAGE_SIZE  = 64;

    // Smallest w with 2**w >= n.
    function automatic int unsigned clog2(input longint unsigned n);
        int unsigned     w;
        longint unsigned v;
        w = 0;
        v = 64'd1;
        while (v < n) begin
            v = v << 1;
            w = w + 1;
        end
        return w;
    endfunction

    // Bits needed to hold the full-precision box sum without loss.
    function automatic int unsigned acc_width(input int unsigned dw,
                                              input int unsigned dch,
                                              input int unsigned fs);
        longint unsigned max_sum;
        max_sum = 64'(dch) * 64'(fs) * 64'(fs) * ((64'd1 << dw) - 64'd1);
        return clog2(max_sum + 64'd1);
    endfunction

    function automatic longint unsigned valid_count(input int unsigned w,
                                                    input int unsigned f,
                                                    input int unsigned h);
        return 64'(w - f + 1) * 64'(h - f + 1);
    endfunction

    function automatic int unsigned pix_width(input int unsigned dw, input int unsigned dch);
        return dw * dch;
    endfunction

    function automatic int unsigned out_width(input int unsigned qw, input int unsigned qch);
        return qw * qch;
    endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// Pixel-in / result-out stream bundle for conv_layer_engine.
interface conv_layer_engine_if
    import conv_layer_engine_pkg::*;
#(
    parameter int unsigned D_WIDTH    = DEF_D_WIDTH,
    parameter int unsigned Q_WIDTH    = DEF_Q_WIDTH,
    parameter int unsigned D_CHANNELS = DEF_D_CHANNELS,
    parameter int unsigned Q_CHANNELS = DEF_Q_CHANNELS
);
    logic                                               clk_en;
    logic [pix_width(D_WIDTH, D_CHANNELS)-1:0]          input_data;
    logic [out_width(Q_WIDTH, Q_CHANNELS)-1:0]          output_data;
    logic                                               valid;

    modport master (output clk_en, output input_data, input output_data, input valid);
    modport slave  (input clk_en, input input_data, output output_data, output valid);
endinterface

// File: rtl/conv_line_buffer.sv
// One image-row delay line: dout_c is the sample written DEPTH enabled clocks ago.
module conv_line_buffer
    import conv_layer_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(64'(DEPTH)) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Read-before-write at the same slot gives exactly DEPTH cycles of delay.
    assign dout_c = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (en) begin
            mem[ptr] <= din;
            ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end
endmodule

// File: rtl/conv_layer_engine.sv
// Streaming FILTER_SIZE x FILTER_SIZE all-ones convolution (box sum) over a raster pixel stream.
// Define SATURATE_EN to clamp results to 2**Q_WIDTH-1 instead of wrapping.
module conv_layer_engine
    import conv_layer_engine_pkg::*;
#(
    parameter int unsigned D_WIDTH     = DEF_D_WIDTH,
    parameter int unsigned Q_WIDTH     = DEF_Q_WIDTH,
    parameter int unsigned D_CHANNELS  = DEF_D_CHANNELS,
    parameter int unsigned Q_CHANNELS  = DEF_Q_CHANNELS,
    parameter int unsigned FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int unsigned IMAGE_SIZE  = DEF_IMAGE_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    conv_layer_engine_if.slave bus
);
    localparam int unsigned PIX_W = pix_width(D_WIDTH, D_CHANNELS);
    localparam int unsigned ACC_W = acc_width(D_WIDTH, D_CHANNELS, FILTER_SIZE);
    localparam int unsigned COL_W = (IMAGE_SIZE > 1) ? clog2(64'(IMAGE_SIZE)) : 1;
    localparam int unsigned ROW_W = clog2(64'(FILTER_SIZE));

    logic [PIX_W-1:0] lb_out [FILTER_SIZE-1];
    logic [PIX_W-1:0] col_in [FILTER_SIZE];
    logic [PIX_W-1:0] win    [FILTER_SIZE][FILTER_SIZE-1];
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [ACC_W-1:0] acc_c;
    logic [Q_WIDTH-1:0] result_c;
    logic               win_valid_c;

    // Cascaded line buffers: stage g outputs the pixel g+1 rows above the current one.
    for (genvar g = 0; g < int'(FILTER_SIZE) - 1; g++) begin : g_lb
        logic [PIX_W-1:0] lb_din;
        if (g == 0) begin : g_first
            assign lb_din = bus.input_data;
        end else begin : g_chain
            assign lb_din = lb_out[g-1];
        end
        conv_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMAGE_SIZE)) u_lb (
            .clk    (clk),
            .rst    (rst),
            .en     (bus.clk_en),
            .din    (lb_din),
            .dout_c (lb_out[g])
        );
    end

    // Incoming window column, oldest row at index 0.
    always_comb begin
        col_in[FILTER_SIZE-1] = bus.input_data;
        for (int r = 0; r < int'(FILTER_SIZE) - 1; r++) col_in[r] = lb_out[int'(FILTER_SIZE) - 2 - r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(FILTER_SIZE); r++)
                for (int k = 0; k < int'(FILTER_SIZE) - 1; k++) win[r][k] <= '0;
        end else if (bus.clk_en) begin
            for (int r = 0; r < int'(FILTER_SIZE); r++) begin
                for (int k = 0; k < int'(FILTER_SIZE) - 2; k++) win[r][k] <= win[r][k+1];
                win[r][FILTER_SIZE-2] <= col_in[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.clk_en) begin
            if (col == COL_W'(IMAGE_SIZE - 1)) begin
                col <= '0;
                if (row != ROW_W'(FILTER_SIZE - 1)) row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign win_valid_c = (col >= COL_W'(FILTER_SIZE - 1)) && (row == ROW_W'(FILTER_SIZE - 1));

    // Stored columns plus the incoming column form the complete window.
    always_comb begin
        acc_c = '0;
        for (int r = 0; r < int'(FILTER_SIZE); r++) begin
            for (int ch = 0; ch < int'(D_CHANNELS); ch++) begin
                acc_c = acc_c + ACC_W'(col_in[r][ch*D_WIDTH +: D_WIDTH]);
                for (int k = 0; k < int'(FILTER_SIZE) - 1; k++)
                    acc_c = acc_c + ACC_W'(win[r][k][ch*D_WIDTH +: D_WIDTH]);
            end
        end
    end

`ifdef SATURATE_EN
    localparam int unsigned EXT_W = ((ACC_W > Q_WIDTH) ? ACC_W : Q_WIDTH) + 1;
    localparam logic [Q_WIDTH-1:0] Q_MAX = {Q_WIDTH{1'b1}};
    assign result_c = (EXT_W'(acc_c) > EXT_W'(Q_MAX)) ? Q_MAX : Q_WIDTH'(acc_c);
`else
    assign result_c = Q_WIDTH'(acc_c);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.output_data <= '0;
            bus.valid       <= 1'b0;
        end else begin
            bus.valid <= bus.clk_en && win_valid_c;
            if (bus.clk_en && win_valid_c) bus.output_data <= {Q_CHANNELS{result_c}};
        end
    end
endmodule

// File: tb/tb_conv_layer_engine.sv
// Self-checking bench for conv_layer_engine: table-driven frames against a box-sum image model.
module tb_conv_layer_engine;
    import conv_layer_engine_pkg::*;

    localparam int W  = 64;
    localparam int H  = 32;
    localparam int F  = 5;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_layer_engine_if #(.D_WIDTH(8), .Q_WIDTH(16), .D_CHANNELS(3), .Q_CHANNELS(5)) bus ();
    conv_layer_engine_if #(.D_WIDTH(8), .Q_WIDTH(14), .D_CHANNELS(3), .Q_CHANNELS(5)) bus14 ();

    assign bus14.clk_en     = bus.clk_en;
    assign bus14.input_data = bus.input_data;

    conv_layer_engine #(.D_WIDTH(8), .Q_WIDTH(16), .D_CHANNELS(3), .Q_CHANNELS(5),
                        .FILTER_SIZE(5), .IMAGE_SIZE(64)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    conv_layer_engine #(.D_WIDTH(8), .Q_WIDTH(14), .D_CHANNELS(3), .Q_CHANNELS(5),
                        .FILTER_SIZE(5), .IMAGE_SIZE(64)) dut14 (
        .clk (clk), .rst (rst), .bus (bus14)
    );

    int errors = 0;
    int checks = 0;
    int img [H][W][DC];
    logic [15:0] last16;
    logic [13:0] last14;

    typedef struct {
        string name;
        int    mode;       // 0 ones, 1 all-255, 2 ramp, 3 random
        int    en_mode;    // 0 always on, 1 low every third cycle, 2 random gaps
        int    npix;
        int    exp_pulses;
        int    exp_first;
        int    exp_const;  // spec-given result for constant images, -1 otherwise
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_q(input int sum, input int qw);
        int mx;
        mx = (1 << qw) - 1;
`ifdef SATURATE_EN
        return (sum > mx) ? mx : sum;
`else
        return sum & mx;
`endif
    endfunction

    function automatic logic [79:0] rep16(input logic [15:0] v);
        return {5{v}};
    endfunction

    function automatic logic [69:0] rep14(input logic [13:0] v);
        return {5{v}};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.clk_en = 1'b0;
        bus.input_data = 24'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last16 = '0;
        last14 = '0;
        check("reset_valid", 128'(bus.valid), 128'(0));
        check("reset_data", 128'(bus.output_data), 128'(0));
        check("reset_valid14", 128'(bus14.valid), 128'(0));
    endtask

    task automatic disabled_cycle();
        bus.clk_en = 1'b0;
        bus.input_data = 24'($urandom);
        @(posedge clk);
        #1;
        check("valid_when_disabled", 128'(bus.valid), 128'(0));
        check("hold_when_disabled", 128'(bus.output_data), 128'(rep16(last16)));
    endtask

    task automatic run_frame(input int mode, input int en_mode, input int npix, input int exp_const,
                             output int pulses, output int first_p);
        int cyc;
        int r, c, sum, e16, e14;
        logic [7:0]  s;
        logic [23:0] pix;
        bit exp_v;
        pulses = 0;
        first_p = -1;
        cyc = 0;
        for (int p = 0; p < npix; p++) begin
            r = p / W;
            c = p % W;
            if (en_mode == 1 && (cyc % 3) == 2) begin
                disabled_cycle();
                cyc++;
            end
            if (en_mode == 2 && $urandom_range(0, 3) == 0) disabled_cycle();
            for (int ch = 0; ch < DC; ch++) begin
                case (mode)
                    0:       s = 8'd1;
                    1:       s = 8'd255;
                    2:       s = 8'((p + ch) % 256);
                    default: s = 8'($urandom);
                endcase
                img[r][c][ch] = int'(s);
                pix[23 - 8*ch -: 8] = s;
            end
            bus.input_data = pix;
            bus.clk_en = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            exp_v = (r >= F - 1) && (c >= F - 1);
            check("valid", 128'(bus.valid), 128'(exp_v));
            check("valid14", 128'(bus14.valid), 128'(exp_v));
            if (exp_v) begin
                sum = 0;
                for (int dr = 0; dr < F; dr++)
                    for (int dc = 0; dc < F; dc++)
                        for (int ch = 0; ch < DC; ch++)
                            sum += img[r - F + 1 + dr][c - F + 1 + dc][ch];
                e16 = exp_q(sum, 16);
                e14 = exp_q(sum, 14);
                pulses++;
                if (first_p < 0) first_p = p;
                check("box_sum_q16", 128'(bus.output_data), 128'(rep16(16'(e16))));
                check("box_sum_q14", 128'(bus14.output_data), 128'(rep14(14'(e14))));
                if (exp_const >= 0) begin
                    check("const_q16", 128'(bus.output_data), 128'(rep16(16'(exp_q(exp_const, 16)))));
                    check("const_q14", 128'(bus14.output_data), 128'(rep14(14'(exp_q(exp_const, 14)))));
                end
                last16 = 16'(e16);
                last14 = 14'(e14);
            end else begin
                check("hold_q16", 128'(bus.output_data), 128'(rep16(last16)));
                check("hold_q14", 128'(bus14.output_data), 128'(rep14(last14)));
            end
        end
        bus.clk_en = 1'b0;
    endtask

    initial begin
        vec_t vecs [5];
        int pulses, first_p;

        vecs[0] = '{"ones",        0, 0, W*H, 1680, 260, 75};
        vecs[1] = '{"all255",      1, 0, W*H, 1680, 260, 19125};
        vecs[2] = '{"ramp",        2, 0, W*H, 1680, 260, -1};
        vecs[3] = '{"ramp_toggle", 2, 1, W*H, 1680, 260, -1};
        vecs[4] = '{"random_gaps", 3, 2, W*H, 1680, 260, -1};

        rst = 1'b1;
        bus.clk_en = 1'b0;
        bus.input_data = '0;
        last16 = '0;
        last14 = '0;
        #12;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_frame(vecs[i].mode, vecs[i].en_mode, vecs[i].npix, vecs[i].exp_const, pulses, first_p);
            check({vecs[i].name, "_count"}, 128'(pulses), 128'(vecs[i].exp_pulses));
            check({vecs[i].name, "_first"}, 128'(first_p), 128'(vecs[i].exp_first));
        end

        // Reset in the middle of a frame, then a fresh frame must start from row 0, col 0.
        do_reset();
        run_frame(2, 0, 1000, -1, pulses, first_p);
        check("partial_count", 128'(pulses), 128'(11 * 60 + (1000 - 15 * 64 - 4)));
        do_reset();
        run_frame(2, 0, W*H, -1, pulses, first_p);
        check("post_reset_count", 128'(pulses), 128'(valid_count(W, F, H)));
        check("post_reset_first", 128'(first_p), 128'(260));

        // Idle with enable low: nothing may fire and data must hold.
        for (int i = 0; i < 5; i++) disabled_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_layer_engine.md
Name: conv_layer_engine

Overview:
Streaming 2-D convolution layer for the image pipeline. It accepts one multi-channel pixel per enabled clock in raster order, with rows of IMAGE_SIZE pixels. Once every FILTER_SIZE x FILTER_SIZE window is fully inside the image, it emits one multi-channel result per window. All kernel weights are +1, so every output channel carries the same box sum over all input channels and all window taps.

Parameters:
D_WIDTH, 8, bits per input channel sample (unsigned)
Q_WIDTH, 16, bits per output channel result (unsigned)
D_CHANNELS, 3, number of input channels
Q_CHANNELS, 5, number of output channels
FILTER_SIZE, 5, square kernel edge length (>=2)
IMAGE_SIZE, 64, pixels per image row

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clk_en  input  1  advance enable; the pipeline moves only when high
input_data  input  D_CHANNELS*D_WIDTH  one pixel; channel 0 in the MSBs, channel D_CHANNELS-1 in the LSBs
output_data  output  Q_CHANNELS*Q_WIDTH  result; channel 0 in the MSBs
valid  output  1  output_data holds a new window result this cycle

Behaviour:
- Reset (async assert, sampled release): line buffers, window registers, column counter, row counter, output_data and valid all go to 0.
- Sampling:
  - input_data is sampled on each rising clk with clk_en=1. No handshake and no backpressure.
  - Pixel stream is contiguous raster order; image height is unbounded.
- Storage:
  - FILTER_SIZE-1 line buffers of IMAGE_SIZE entries, each D_CHANNELS*D_WIDTH wide.
  - A FILTER_SIZE x FILTER_SIZE shift-register window per channel.
- Counters:
  - col counts 0..IMAGE_SIZE-1 and wraps to 0.
  - row increments on col wrap and saturates at FILTER_SIZE-1.
- Window validity: the window ending at the current pixel is valid when col >= FILTER_SIZE-1 and row >= FILTER_SIZE-1, evaluated for the pixel being sampled.
- Arithmetic:
  - sum = Σ over all channels and taps of the zero-extended samples.
  - Internal accumulator width is ceil(log2(D_CHANNELS*FILTER_SIZE²*(2^D_WIDTH-1)+1)) bits.
  - Result is truncated to the low Q_WIDTH bits (wrap-around) unless SATURATE_EN is defined.
  - Every Q_CHANNELS slot of output_data carries the identical value.
- Latency: exactly 1 clock. The edge that samples a window's bottom-right pixel with clk_en=1 registers output_data and sets valid=1 on that same edge. The adder tree is combinational into the output register.
- valid: a single-cycle pulse per window. It is registered 0 on any edge where clk_en=0 or the sampled pixel does not complete a window. output_data holds its last value when valid=0.
- Output count: for an IMAGE_SIZE x H image, exactly (IMAGE_SIZE-FILTER_SIZE+1)*(H-FILTER_SIZE+1) valid pulses. There are none for the first FILTER_SIZE-1 rows, nor for the first FILTER_SIZE-1 columns of each row. Windows never straddle row boundaries.
- clk_en low: counters, buffers and window freeze. The next enabled pixel continues the same stream seamlessly.
- Reset mid-frame: discards all history; the next pixel is treated as row 0, col 0.

Optional Feature:
SATURATE_EN
- Defined: if the full-precision sum exceeds 2^Q_WIDTH-1, output is clamped to 2^Q_WIDTH-1.
- Undefined: output is the low Q_WIDTH bits of the sum.

Decomposition:
- Shared package: a clog2 function, the accumulator-width constant, the valid-output-count function ((W-F+1)*(H-F+1)), and the pixel packing/unpacking width constants.
- One sub-module, conv_line_buffer: a single IMAGE_SIZE-deep delay line with enable, instantiated FILTER_SIZE-1 times.

Test Plan:
- Defaults, 64x32 image, every channel sample = 1 -> exactly 1680 valid pulses; every output_data slot = 75 (0x004B).
- Defaults, all samples = 255 -> every result = 19125 (0x4AB5); no overflow.
- Ramp: pixel index p (row-major), channel c sample = (p+c) mod 256 -> each valid result equals the software box sum over 3 channels x 25 taps. The first valid arrives 1 clock after sampling pixel index 4*64+4 = 260.
- Toggle clk_en low every third cycle during a 64x32 frame -> identical result sequence and count (1680); valid never high on the edge after a disabled cycle.
- Q_WIDTH=14, all samples = 255 -> with SATURATE_EN, result 16383; without it, 19125 mod 16384 = 2741.
- Assert rst for 1 cycle at pixel 1000 of a frame, then restart a fresh 64x32 frame -> no valid for 260 enabled pixels after release; then 1680 correct results.
